blob_tracking_select: RTL and testbench

Downstream consumer of `blob_sorting`: once sorting finishes, it walks the sorted blob table in shared SRAM and selects the single largest blob of a requested color class. It then reports that blob's centroid and pixel count to the tracking/servo logic. The block is read-only on the memory bus and runs one scan per rising edge of its enable.

---
 rtl/blob_tracking_select.sv | 101 ++++++++++
 tb/tb_blob_tracking_select.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/blob_tracking_select.sv
// blob_tracking_select: scans the sorted blob table for the largest blob of target_color (BLOB_TRACKING_ANY_COLOR_EN: target_color 8'hFF matches any color)
module blob_tracking_select #(
  parameter int BLOB_BASE_ADDR = 200000,
  parameter int MAX_BLOBS = 1000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        enable_blob_tracking,
  input  logic [7:0]  target_color,
  input  logic [7:0]  minimum_blob_size,
  input  logic [31:0] data_read,
  output logic [17:0] address,
  output logic        blob_tracking_done,
  output logic        target_found,
  output logic [8:0]  target_x,
  output logic [8:0]  target_y,
  output logic [23:0] target_size
);
  localparam logic [17:0] BASE = 18'(BLOB_BASE_ADDR);
  localparam int IW = $clog2(MAX_BLOBS + 1);
  localparam logic [IW-1:0] LAST = IW'(MAX_BLOBS - 1);
  typedef enum logic [2:0] {IDLE, CAP0, CAP1, CAP2, EVAL, DONE} state_t;
  state_t state, state_n;
  logic en_q, start, color_ok, qualify;
  logic [IW-1:0] idx;
  logic [17:0] rec_addr, addr_n;
  logic [8:0] x_min, y_min, x_max, y_max;
  logic [7:0] color;
  logic [23:0] count;
  assign start = enable_blob_tracking & ~en_q;
`ifdef BLOB_TRACKING_ANY_COLOR_EN
  assign color_ok = target_color == 8'hFF || color == target_color;
`else
  assign color_ok = color == target_color;
`endif
  assign qualify = color_ok && count >= {16'd0, minimum_blob_size} && x_max >= x_min &&
                   y_max >= y_min && count > target_size;
  always_comb begin
    state_n = state;
    addr_n = address;
    case (state)
      IDLE: state_n = start ? CAP0 : IDLE;
      CAP0: begin
        state_n = data_read == 32'hFFFF_FFFF ? DONE : CAP1;
        addr_n = rec_addr + 18'd1;
      end
      CAP1: begin
        state_n = CAP2;
        addr_n = rec_addr + 18'd2;
      end
      CAP2: state_n = EVAL;
      EVAL: begin
        state_n = idx == LAST ? DONE : CAP0;
        addr_n = rec_addr + 18'd3;
      end
      DONE: state_n = enable_blob_tracking ? DONE : IDLE;
      default: state_n = IDLE;
    endcase
    if (!enable_blob_tracking && state inside {CAP0, CAP1, CAP2, EVAL}) state_n = IDLE;
    if (state_n == IDLE) addr_n = BASE;
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= IDLE;
      en_q <= 1'b0;
      address <= BASE;
      rec_addr <= BASE;
      idx <= '0;
      {x_min, y_min, x_max, y_max, color, count} <= '0;
      blob_tracking_done <= 1'b0;
      target_found <= 1'b0;
      target_x <= '0;
      target_y <= '0;
      target_size <= '0;
    end else begin
      state <= state_n;
      en_q <= enable_blob_tracking;
      address <= addr_n;
      blob_tracking_done <= state == DONE && enable_blob_tracking;
      if (state == IDLE && start) begin
        target_found <= 1'b0;
        target_size <= '0;
        idx <= '0;
        rec_addr <= BASE;
      end
      if (state == CAP0) {x_min, y_min} <= {data_read[24:16], data_read[8:0]};
      if (state == CAP1) {x_max, y_max} <= {data_read[24:16], data_read[8:0]};
      if (state == CAP2) {color, count} <= data_read;
      if (state == EVAL) begin
        idx <= idx + IW'(1);
        rec_addr <= rec_addr + 18'd3;
        if (qualify) begin
          target_found <= 1'b1;
          target_size <= count;
          target_x <= 9'(({1'b0, x_min} + {1'b0, x_max}) >> 1);
          target_y <= 9'(({1'b0, y_min} + {1'b0, y_max}) >> 1);
        end
      end
    end
  end
endmodule

// File: tb/tb_blob_tracking_select.sv
// tb_blob_tracking_select: directed and randomized scans checked against a behavioural selection model
module tb_blob_tracking_select;
  localparam int BASE = 200000;
  localparam int MAXB = 8;
  localparam int MW = 64;
`ifdef BLOB_TRACKING_ANY_COLOR_EN
  localparam bit ANY = 1'b1;
`else
  localparam bit ANY = 1'b0;
`endif
  logic clk = 1'b0, reset_n = 1'b0, enable = 1'b0;
  logic [7:0] tcol = 8'd0, tmin = 8'd0;
  logic [31:0] data_read;
  logic [17:0] address;
  logic done, found;
  logic [8:0] tx, ty;
  logic [23:0] tsize;
  logic [31:0] mem [0:MW-1];
  int bx0 [0:MAXB], by0 [0:MAXB], bx1 [0:MAXB], by1 [0:MAXB], bcol [0:MAXB], bsz [0:MAXB];
  int checks = 0, errors = 0;
  int exp_found = 0, exp_x = 0, exp_y = 0, exp_size = 0;
  int off;
  always #5 clk = ~clk;
  blob_tracking_select #(.BLOB_BASE_ADDR(BASE), .MAX_BLOBS(MAXB)) dut (
    .clk(clk), .reset_n(reset_n), .enable_blob_tracking(enable), .target_color(tcol),
    .minimum_blob_size(tmin), .data_read(data_read), .address(address),
    .blob_tracking_done(done), .target_found(found), .target_x(tx), .target_y(ty),
    .target_size(tsize)
  );
  always_comb begin
    off = int'(address) - BASE;
    data_read = (off >= 0 && off < MW) ? mem[off[5:0]] : 32'hFFFF_FFFF;
  end
  task automatic clear_mem();
    for (int i = 0; i < MW; i++) mem[i] = 32'hFFFF_FFFF;
  endtask
  task automatic put_blob(input int j, input int x0, input int y0, input int x1, input int y1,
                          input int c, input int s);
    logic [31:0] w;
    w = $urandom & 32'hFE00_FE00;
    w[24:16] = 9'(x0);
    w[8:0] = 9'(y0);
    if (w == 32'hFFFF_FFFF) w[31] = 1'b0;
    mem[3*j] = w;
    w = $urandom & 32'hFE00_FE00;
    w[24:16] = 9'(x1);
    w[8:0] = 9'(y1);
    mem[3*j+1] = w;
    mem[3*j+2] = {8'(c), 24'(s)};
    bx0[j] = x0; by0[j] = y0; bx1[j] = x1; by1[j] = y1; bcol[j] = c; bsz[j] = s;
  endtask
  task automatic model(input int nb, output int cyc);
    int n;
    n = nb < MAXB ? nb : MAXB;
    exp_found = 0;
    exp_size = 0;
    for (int j = 0; j < n; j++)
      if ((bcol[j] == int'(tcol) || (ANY && tcol == 8'hFF)) && bsz[j] >= int'(tmin) &&
          bx1[j] >= bx0[j] && by1[j] >= by0[j] && bsz[j] > exp_size) begin
        exp_found = 1;
        exp_size = bsz[j];
        exp_x = (bx0[j] + bx1[j]) / 2;
        exp_y = (by0[j] + by1[j]) / 2;
      end
    cyc = nb < MAXB ? 4 * nb + 3 : 4 * MAXB + 2;
  endtask
  task automatic do_scan(output int cyc);
    @(negedge clk);
    enable = 1'b1;
    cyc = -1;
    for (int k = 1; k <= 200; k++) begin
      @(negedge clk);
      if (done) begin
        cyc = k;
        break;
      end
    end
  endtask
  task automatic stop_scan();
    enable = 1'b0;
    repeat (2) @(negedge clk);
  endtask
  task automatic test_reset();
    clear_mem();
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (address !== 18'(BASE)) begin errors++; $display("FAIL reset_address: got %0d want %0d", address, BASE); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
    checks++; if (found !== 1'b0) begin errors++; $display("FAIL reset_found: got %b want 0", found); end
    checks++; if (tx !== 9'd0 || ty !== 9'd0) begin errors++; $display("FAIL reset_xy: got %0d,%0d want 0,0", tx, ty); end
    checks++; if (tsize !== 24'd0) begin errors++; $display("FAIL reset_size: got %0d want 0", tsize); end
    reset_n = 1'b1;
    exp_x = 0;
    exp_y = 0;
    @(negedge clk);
  endtask
  task automatic test_three_blobs();
    int c, ec;
    clear_mem();
    tcol = 8'd2;
    tmin = 8'd10;
    put_blob(0, 0, 0, 10, 10, 2, 20);
    put_blob(1, 100, 40, 201, 61, 2, 50);
    put_blob(2, 300, 300, 310, 320, 2, 50);
    model(3, ec);
    do_scan(c);
    checks++; if (c !== 15) begin errors++; $display("FAIL three_latency: got %0d want 15", c); end
    checks++; if (found !== 1'b1) begin errors++; $display("FAIL three_found: got %b want 1", found); end
    checks++; if (tsize !== 24'd50) begin errors++; $display("FAIL three_size: got %0d want 50", tsize); end
    checks++; if (tx !== 9'd150 || ty !== 9'd50) begin errors++; $display("FAIL three_tie_xy: got %0d,%0d want 150,50", tx, ty); end
  endtask
  task automatic test_hold();
    logic [17:0] a;
    int bad;
    a = address;
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (!done || address !== a || tsize !== 24'd50) bad++;
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL hold_no_rescan: got %0d bad cycles want 0", bad); end
    stop_scan();
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL hold_done_drop: got %b want 0", done); end
  endtask
  task automatic test_terminator();
    int c;
    clear_mem();
    do_scan(c);
    checks++; if (c !== 3) begin errors++; $display("FAIL term_latency: got %0d want 3", c); end
    checks++; if (found !== 1'b0) begin errors++; $display("FAIL term_found: got %b want 0", found); end
    checks++; if (tsize !== 24'd0) begin errors++; $display("FAIL term_size: got %0d want 0", tsize); end
    stop_scan();
  endtask
  task automatic test_min_size();
    int c;
    clear_mem();
    tcol = 8'd2;
    tmin = 8'd10;
    put_blob(0, 10, 20, 30, 41, 2, 9);
    put_blob(1, 10, 20, 31, 41, 2, 10);
    do_scan(c);
    checks++; if (c !== 11) begin errors++; $display("FAIL min_latency: got %0d want 11", c); end
    checks++; if (found !== 1'b1 || tsize !== 24'd10) begin errors++; $display("FAIL min_size: got found=%b size=%0d want 1,10", found, tsize); end
    checks++; if (tx !== 9'd20 || ty !== 9'd30) begin errors++; $display("FAIL min_xy: got %0d,%0d want 20,30", tx, ty); end
    stop_scan();
  endtask
  task automatic test_bad_box();
    int c;
    clear_mem();
    tcol = 8'd2;
    tmin = 8'd10;
    put_blob(0, 100, 5, 50, 9, 2, 200);
    put_blob(1, 0, 0, 20, 40, 2, 30);
    put_blob(2, 1, 50, 3, 10, 2, 150);
    do_scan(c);
    checks++; if (tsize !== 24'd30) begin errors++; $display("FAIL badbox_size: got %0d want 30", tsize); end
    checks++; if (tx !== 9'd10 || ty !== 9'd20) begin errors++; $display("FAIL badbox_xy: got %0d,%0d want 10,20", tx, ty); end
    stop_scan();
  endtask
  task automatic test_ff_color();
    int c;
    clear_mem();
    tcol = 8'hFF;
    tmin = 8'd0;
    put_blob(0, 0, 0, 100, 100, 3, 40);
    put_blob(1, 200, 200, 202, 204, 255, 20);
    do_scan(c);
    checks++; if (tsize !== (ANY ? 24'd40 : 24'd20)) begin errors++; $display("FAIL ff_size: got %0d want %0d", tsize, ANY ? 40 : 20); end
    checks++; if (tx !== (ANY ? 9'd50 : 9'd201)) begin errors++; $display("FAIL ff_x: got %0d want %0d", tx, ANY ? 50 : 201); end
    stop_scan();
  endtask
  task automatic test_abort();
    int c, ec, seen;
    clear_mem();
    tcol = 8'd2;
    tmin = 8'd10;
    put_blob(0, 4, 6, 8, 10, 2, 30);
    put_blob(1, 20, 20, 40, 40, 2, 40);
    put_blob(2, 60, 70, 80, 90, 2, 45);
    @(negedge clk);
    enable = 1'b1;
    repeat (6) @(negedge clk);
    enable = 1'b0;
    @(negedge clk);
    checks++; if (address !== 18'(BASE)) begin errors++; $display("FAIL abort_address: got %0d want %0d", address, BASE); end
    checks++; if (found !== 1'b1 || tsize !== 24'd30 || tx !== 9'd6 || ty !== 9'd8) begin errors++; $display("FAIL abort_partial: got %b,%0d,%0d,%0d want 1,30,6,8", found, tsize, tx, ty); end
    seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (done) seen++;
    end
    checks++; if (seen !== 0) begin errors++; $display("FAIL abort_done: got %0d done cycles want 0", seen); end
    model(3, ec);
    do_scan(c);
    checks++; if (c !== ec) begin errors++; $display("FAIL restart_latency: got %0d want %0d", c, ec); end
    checks++; if (tsize !== 24'(exp_size) || tx !== 9'(exp_x) || ty !== 9'(exp_y)) begin errors++; $display("FAIL restart_result: got %0d,%0d,%0d want %0d,%0d,%0d", tsize, tx, ty, exp_size, exp_x, exp_y); end
    stop_scan();
  endtask
  task automatic test_reset_mid();
    clear_mem();
    tcol = 8'd1;
    tmin = 8'd0;
    put_blob(0, 10, 10, 20, 20, 1, 5);
    put_blob(1, 30, 30, 50, 50, 1, 9);
    @(negedge clk);
    enable = 1'b1;
    repeat (8) @(negedge clk);
    checks++; if (found !== 1'b1) begin errors++; $display("FAIL midreset_pre_found: got %b want 1", found); end
    reset_n = 1'b0;
    @(negedge clk);
    checks++; if (address !== 18'(BASE) || done !== 1'b0) begin errors++; $display("FAIL midreset_ctl: got addr=%0d done=%b want %0d,0", address, done, BASE); end
    checks++; if (found !== 1'b0 || tsize !== 24'd0 || tx !== 9'd0 || ty !== 9'd0) begin errors++; $display("FAIL midreset_out: got %b,%0d,%0d,%0d want 0,0,0,0", found, tsize, tx, ty); end
    enable = 1'b0;
    reset_n = 1'b1;
    exp_x = 0;
    exp_y = 0;
    repeat (2) @(negedge clk);
  endtask
  task automatic test_random();
    int c, ec, nb, x0, y0, x1, y1;
    for (int t = 0; t < 24; t++) begin
      clear_mem();
      tcol = ($urandom_range(0, 4) == 4) ? 8'hFF : 8'($urandom_range(0, 3));
      tmin = 8'($urandom_range(0, 40));
      nb = $urandom_range(0, MAXB);
      for (int j = 0; j < nb; j++) begin
        x0 = $urandom_range(0, 511);
        y0 = $urandom_range(0, 511);
        x1 = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 511) : x0 + $urandom_range(0, 511 - x0);
        y1 = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 511) : y0 + $urandom_range(0, 511 - y0);
        put_blob(j, x0, y0, x1, y1,
                 ($urandom_range(0, 5) == 0) ? 255 : $urandom_range(0, 3),
                 ($urandom_range(0, 7) == 0) ? $urandom_range(0, 24'hFFFFFF) : $urandom_range(0, 60));
      end
      if (nb == MAXB) put_blob(MAXB, 1, 1, 9, 9, int'(tcol), 24'hFFFFFF);
      model(nb, ec);
      do_scan(c);
      checks++; if (c !== ec) begin errors++; $display("FAIL rand%0d_latency: got %0d want %0d", t, c, ec); end
      checks++; if (found !== exp_found[0]) begin errors++; $display("FAIL rand%0d_found: got %b want %0d", t, found, exp_found); end
      checks++; if (tsize !== 24'(exp_size)) begin errors++; $display("FAIL rand%0d_size: got %0d want %0d", t, tsize, exp_size); end
      checks++; if (tx !== 9'(exp_x) || ty !== 9'(exp_y)) begin errors++; $display("FAIL rand%0d_xy: got %0d,%0d want %0d,%0d", t, tx, ty, exp_x, exp_y); end
      stop_scan();
    end
  endtask
  initial begin
    test_reset();
    test_three_blobs();
    test_hold();
    test_terminator();
    test_min_size();
    test_bad_box();
    test_ff_color();
    test_abort();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
